stable_trend_detector: RTL

Parametrised plateau-and-trend detector for sampled physiological values (heart rate, stress level). Watches a WIDTH-bit sample stream, declares a plateau once STABLE_LEN consecutive valid samples are equal, and compares the plateau against the last accepted reference to report a rise, fall or no change, with a hysteresis band and the change magnitude. Sits after the input conditioning stage on the slow sample clock and feeds the rocking-control decision logic.

---
 rtl/stable_trend_detector_if.sv | 26 ++
 rtl/stable_trend_detector.sv | 101 ++++++++++
 2 files changed

// File: rtl/stable_trend_detector_if.sv
// Sample stream in, plateau/trend results out.
// master = sample producer, slave = detector.
interface stable_trend_detector_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] sample_in;
  logic             sample_valid;
  logic             stable_pulse;
  logic [WIDTH-1:0] stable_value;
  logic             ref_valid;
  logic             rose;
  logic             fell;
  logic [WIDTH-1:0] delta;

  modport master (
    output sample_in, sample_valid,
    input  stable_pulse, stable_value, ref_valid,
    input  rose, fell, delta
  );

  modport slave (
    input  sample_in, sample_valid,
    output stable_pulse, stable_value, ref_valid,
    output rose, fell, delta
  );
endinterface

// File: rtl/stable_trend_detector.sv
// Plateau detector with hysteretic rise/fall trend
// against the last accepted reference value.
module stable_trend_detector #(
  parameter int WIDTH      = 6,
  parameter int STABLE_LEN = 4,
  parameter int HYST       = 0,
  parameter int REPEAT     = 0
) (
  input logic                   slow,
  input logic                   reset,
  stable_trend_detector_if.slave bus
);

  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [3:0] RUN_MAX = 4'(STABLE_LEN);
  localparam logic [3:0] RUN_PRE = 4'(STABLE_LEN - 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT - 1);
  localparam logic [WIDTH:0] HYST_W = (WIDTH+1)'(HYST);

  logic [WIDTH-1:0] last_sample;
  logic             have_last;
  logic [3:0]       run;
  logic [RW-1:0]    rpt;
  logic [WIDTH-1:0] ref_value;

  logic             eq;
  logic             sat;
  logic             hit_repeat;
  logic             hit;
  logic [WIDTH:0]   d_full;
  logic             big;
  logic             up;
  logic             down;

  always_comb begin
    eq  = have_last && (bus.sample_in == last_sample);
    sat = (run == RUN_MAX);
    hit_repeat = (REPEAT > 0) && eq && sat
                 && (rpt == RPT_LAST);
    hit = bus.sample_valid
          && ((eq && run == RUN_PRE) || hit_repeat);
    if (bus.sample_in >= ref_value)
      d_full = {1'b0, bus.sample_in} - {1'b0, ref_value};
    else
      d_full = {1'b0, ref_value} - {1'b0, bus.sample_in};
    big  = d_full > HYST_W;
    up   = (bus.sample_in > ref_value) && big;
    down = (bus.sample_in < ref_value) && big;
  end

  always_ff @(posedge slow or posedge reset) begin
    if (reset) begin
      last_sample      <= '0;
      have_last        <= 1'b0;
      run              <= '0;
      rpt              <= '0;
      ref_value        <= '0;
      bus.stable_pulse <= 1'b0;
      bus.stable_value <= '0;
      bus.ref_valid    <= 1'b0;
      bus.rose         <= 1'b0;
      bus.fell         <= 1'b0;
      bus.delta        <= '0;
    end else begin
      bus.stable_pulse <= 1'b0;
      if (bus.sample_valid) begin
        last_sample <= bus.sample_in;
        have_last   <= 1'b1;
        if (eq) begin
          if (!sat)
            run <= run + 4'd1;
          else if (REPEAT > 0)
            rpt <= hit_repeat ? '0 : rpt + RW'(1);
        end else begin
          run <= 4'd1;
          rpt <= '0;
        end
      end
      if (hit) begin
        bus.stable_pulse <= 1'b1;
        bus.stable_value <= bus.sample_in;
        if (!bus.ref_valid) begin
          // first plateau only seeds the reference
          ref_value     <= bus.sample_in;
          bus.ref_valid <= 1'b1;
          bus.rose      <= 1'b0;
          bus.fell      <= 1'b0;
          bus.delta     <= '0;
        end else begin
          bus.delta <= d_full[WIDTH-1:0];
          bus.rose  <= up;
          bus.fell  <= down;
          // small drift keeps comparing to the old reference
          if (up || down)
            ref_value <= bus.sample_in;
        end
      end
    end
  end

endmodule
